// File: rtl/regfile_read_arbiter.sv
// Round-robin arbiter sharing one 16:1 register-file read mux between NUM_REQ requesters.
// One read per grant: IDLE/RESP arbitrate, READ drives the select, RESP returns tagged data.
module regfile_read_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int SEL_W   = 4,
  parameter int DATA_W  = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*SEL_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]       grant,
  output logic [SEL_W-1:0]         mux_select,
  input  logic [DATA_W-1:0]        mux_out,
  output logic                     rd_valid,
  output logic [DATA_W-1:0]        rd_data,
  output logic [ID_W-1:0]          rd_id,
  output logic                     busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] cur_id;
  logic [ID_W-1:0] win_id;
  logic [ID_W-1:0] scan_idx;
  logic            win_found;
  logic            can_arb;
  logic            start;

  assign can_arb = (state == IDLE) || (state == RESP);
  assign start   = can_arb && win_found;

  // Scan ptr+1, ptr+2, ... ; ID_W-bit arithmetic wraps because NUM_REQ == 2**ID_W.
  always_comb begin
    // NOTE: every variable written here gets a default first, otherwise a latch is inferred.
    win_found = 1'b0;
    win_id    = '0;
    scan_idx  = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      scan_idx = ptr + ID_W'(i);
      if (!win_found && req[scan_idx]) begin
        win_found = 1'b1;
        win_id    = scan_idx;
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = IDLE;
    unique case (state)
      IDLE:    state_next = win_found ? READ : IDLE;
      READ:    state_next = RESP;
      RESP:    state_next = win_found ? READ : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    busy = (state != IDLE);
  end

  // Registered datapath: winner and its address are latched at the arbitration edge,
  // so address changes during READ never reach the mux.
  always_ff @(posedge clk) begin
    if (reset) begin
      grant      <= '0;
      mux_select <= '0;
      rd_valid   <= 1'b0;
      rd_data    <= '0;
      rd_id      <= '0;
      cur_id     <= '0;
      ptr        <= ID_W'(NUM_REQ - 1);
    end else begin
      grant    <= '0;
      rd_valid <= 1'b0;
      if (start) begin
        grant      <= {{(NUM_REQ-1){1'b0}}, 1'b1} << win_id;
        mux_select <= req_addr[int'(win_id)*SEL_W +: SEL_W];
        cur_id     <= win_id;
      end
      if (state == READ) begin
        rd_data  <= mux_out;
        rd_id    <= cur_id;
        ptr      <= cur_id;
        rd_valid <= 1'b1;
      end
    end
  end

endmodule
